// File: rtl/apb2amm_if.sv
// APB3 completer + Avalon-MM host signal bundle for the apb2amm bridge.
// "slave" is the bridge view; "master" is the view of the APB host plus AMM fabric around it.
interface apb2amm_if;
    logic        APB_PSEL;
    logic        APB_PENABLE;
    logic [31:0] APB_PADDR;
    logic [31:0] APB_PWDATA;
    logic        APB_PWRITE;
    logic [31:0] APB_PRDATA;
    logic        APB_PREADY;
    logic        APB_PSLVERR;
    logic [31:0] amm_address;
    logic [31:0] amm_writedata;
    logic        amm_write;
    logic        amm_read;
    logic [31:0] amm_readdata;
    logic        amm_waitrequest;
    logic        amm_readdatavalid;

    modport slave (
        input  APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWDATA, APB_PWRITE,
        output APB_PRDATA, APB_PREADY, APB_PSLVERR,
        output amm_address, amm_writedata, amm_write, amm_read,
        input  amm_readdata, amm_waitrequest, amm_readdatavalid
    );

    modport master (
        output APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWDATA, APB_PWRITE,
        input  APB_PRDATA, APB_PREADY, APB_PSLVERR,
        input  amm_address, amm_writedata, amm_write, amm_read,
        output amm_readdata, amm_waitrequest, amm_readdatavalid
    );
endinterface

// File: rtl/apb2amm.sv
// APB3 completer to Avalon-MM host bridge, 32-bit, one outstanding command.
// Optional command timeout with PSLVERR completion when APB2AMM_TIMEOUT_EN is defined.
module apb2amm #(
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    apb2amm_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_t;

    state_t      r_state;
    logic        r_wr;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_amm_wr;
    logic        r_amm_rd;
    logic        w_setup;
    logic        w_tmo;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("apb2amm: TIMEOUT must be in 1..65535");
    end

    assign w_setup = bus.APB_PSEL && !bus.APB_PENABLE;

`ifdef APB2AMM_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_pslverr;
    assign w_tmo            = (r_cnt == 16'(TIMEOUT));
    assign bus.APB_PSLVERR  = r_pslverr;
`else
    assign w_tmo            = 1'b0;
    assign bus.APB_PSLVERR  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wr     <= 1'b0;
            r_prdata <= '0;
            r_pready <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_amm_wr <= 1'b0;
            r_amm_rd <= 1'b0;
`ifdef APB2AMM_TIMEOUT_EN
            r_cnt     <= '0;
            r_pslverr <= 1'b0;
`endif
        end else begin
            // PREADY/PSLVERR are one-cycle pulses raised only on the edge entering DONE
            r_pready <= 1'b0;
`ifdef APB2AMM_TIMEOUT_EN
            r_pslverr <= 1'b0;
            if (r_state == CMD || r_state == RDWAIT)
                r_cnt <= r_cnt + 16'd1;
`endif
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_addr   <= bus.APB_PADDR;
                        r_wdata  <= bus.APB_PWDATA;
                        r_wr     <= bus.APB_PWRITE;
                        r_amm_wr <= bus.APB_PWRITE;
                        r_amm_rd <= !bus.APB_PWRITE;
                        r_state  <= CMD;
`ifdef APB2AMM_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                CMD: begin
                    // a genuine completion wins over a timeout landing in the same cycle
                    if (!bus.amm_waitrequest && (r_wr || bus.amm_readdatavalid)) begin
                        r_amm_wr <= 1'b0;
                        r_amm_rd <= 1'b0;
                        r_pready <= 1'b1;
                        r_state  <= DONE;
                        if (!r_wr)
                            r_prdata <= bus.amm_readdata;
                    end else if (w_tmo) begin
                        r_amm_wr <= 1'b0;
                        r_amm_rd <= 1'b0;
                        r_pready <= 1'b1;
                        r_prdata <= '0;
                        r_state  <= DONE;
`ifdef APB2AMM_TIMEOUT_EN
                        r_pslverr <= 1'b1;
`endif
                    end else if (!bus.amm_waitrequest) begin
                        r_amm_rd <= 1'b0;
                        r_state  <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (bus.amm_readdatavalid) begin
                        r_prdata <= bus.amm_readdata;
                        r_pready <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_tmo) begin
                        r_prdata <= '0;
                        r_pready <= 1'b1;
                        r_state  <= DONE;
`ifdef APB2AMM_TIMEOUT_EN
                        r_pslverr <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.APB_PRDATA    = r_prdata;
    assign bus.APB_PREADY    = r_pready;
    assign bus.amm_address   = r_addr;
    assign bus.amm_writedata = r_wdata;
    assign bus.amm_write     = r_amm_wr;
    assign bus.amm_read      = r_amm_rd;

endmodule

// File: tb/tb_apb2amm.sv
// Directed bench for apb2amm: cycle-exact APB and AMM stimulus with hand-computed expectations.
module tb_apb2amm;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    apb2amm_if bus();

    apb2amm #(.TIMEOUT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one rising edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.APB_PSEL    = 1'b1;
        bus.APB_PENABLE = 1'b0;
        bus.APB_PWRITE  = wr;
        bus.APB_PADDR   = addr;
        bus.APB_PWDATA  = data;
    endtask

    task automatic apb_idle();
        bus.APB_PSEL    = 1'b0;
        bus.APB_PENABLE = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.APB_PSEL = 1'b0;
        bus.APB_PENABLE = 1'b0;
        bus.APB_PADDR = '0;
        bus.APB_PWDATA = '0;
        bus.APB_PWRITE = 1'b0;
        bus.amm_readdata = '0;
        bus.amm_waitrequest = 1'b0;
        bus.amm_readdatavalid = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_prdata",  bus.APB_PRDATA, 32'h0);
        chk("rst_pready",  32'(bus.APB_PREADY), 0);
        chk("rst_pslverr", 32'(bus.APB_PSLVERR), 0);
        chk("rst_addr",    bus.amm_address, 32'h0);
        chk("rst_wdata",   bus.amm_writedata, 32'h0);
        chk("rst_cmd",     32'({bus.amm_write, bus.amm_read}), 0);
        reset = 1'b0;
        tick();

        // PSEL&PENABLE in IDLE plus stray readdatavalid: both ignored
        bus.APB_PSEL = 1'b1;
        bus.APB_PENABLE = 1'b1;
        bus.APB_PWRITE = 1'b0;
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("viol_cmd",    32'({bus.amm_write, bus.amm_read}), 0);
        chk("viol_pready", 32'(bus.APB_PREADY), 0);
        chk("stray_prdata", bus.APB_PRDATA, 32'h0);
        apb_idle();
        bus.amm_readdatavalid = 1'b0;
        tick();

        // write 0xDEADBEEF to 0x40, no waitrequest
        apb_setup(1'b1, 32'h40, 32'hDEAD_BEEF);
        tick();
        chk("wr_write", 32'(bus.amm_write), 1);
        chk("wr_read",  32'(bus.amm_read), 0);
        chk("wr_addr",  bus.amm_address, 32'h40);
        chk("wr_data",  bus.amm_writedata, 32'hDEAD_BEEF);
        chk("wr_pready_early", 32'(bus.APB_PREADY), 0);
        bus.APB_PENABLE = 1'b1;
        tick();
        chk("wr_pready",  32'(bus.APB_PREADY), 1);
        chk("wr_pslverr", 32'(bus.APB_PSLVERR), 0);
        chk("wr_write_drop", 32'(bus.amm_write), 0);
        tick();
        chk("wr_pready_pulse", 32'(bus.APB_PREADY), 0);
        apb_idle();
        tick();

        // read 0x80: 3 waitrequest cycles, readdatavalid 2 cycles after accept
        apb_setup(1'b0, 32'h80, 32'h0);
        bus.amm_waitrequest = 1'b1;
        tick();
        chk("rd_read_0", 32'(bus.amm_read), 1);
        chk("rd_addr",   bus.amm_address, 32'h80);
        bus.APB_PENABLE = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("rd_stall_read_%0d", i), 32'(bus.amm_read), 1);
            chk($sformatf("rd_stall_addr_%0d", i), bus.amm_address, 32'h80);
            chk($sformatf("rd_stall_pready_%0d", i), 32'(bus.APB_PREADY), 0);
        end
        bus.amm_waitrequest = 1'b0;
        tick();
        chk("rd_accept_read",   32'(bus.amm_read), 0);
        chk("rd_accept_pready", 32'(bus.APB_PREADY), 0);
        tick();
        chk("rd_wait_pready", 32'(bus.APB_PREADY), 0);
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h1234_5678;
        tick();
        bus.amm_readdatavalid = 1'b0;
        bus.amm_readdata = 32'h0;
        chk("rd_pready", 32'(bus.APB_PREADY), 1);
        chk("rd_prdata", bus.APB_PRDATA, 32'h1234_5678);
        tick();
        apb_idle();
        chk("rd_prdata_hold", bus.APB_PRDATA, 32'h1234_5678);
        chk("rd_pready_pulse", 32'(bus.APB_PREADY), 0);
        tick();

        // read with readdatavalid in the accept cycle
        apb_setup(1'b0, 32'hC4, 32'h0);
        tick();
        bus.APB_PENABLE = 1'b1;
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'hA5A5_A5A5;
        tick();
        bus.amm_readdatavalid = 1'b0;
        chk("rd0_pready", 32'(bus.APB_PREADY), 1);
        chk("rd0_prdata", bus.APB_PRDATA, 32'hA5A5_A5A5);
        chk("rd0_read",   32'(bus.amm_read), 0);
        tick();
        apb_idle();
        tick();

        // back-to-back: write 0x100 then read 0x104 (L=1)
        apb_setup(1'b1, 32'h100, 32'h0000_0011);
        tick();
        bus.APB_PENABLE = 1'b1;
        tick();
        chk("b2b_wr_pready", 32'(bus.APB_PREADY), 1);
        tick();
        apb_setup(1'b0, 32'h104, 32'h0);
        tick();
        chk("b2b_rd_read",  32'(bus.amm_read), 1);
        chk("b2b_rd_write", 32'(bus.amm_write), 0);
        chk("b2b_rd_addr",  bus.amm_address, 32'h104);
        bus.APB_PENABLE = 1'b1;
        tick();
        chk("b2b_rd_cmd_off", 32'({bus.amm_write, bus.amm_read}), 0);
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h55AA_00FF;
        tick();
        bus.amm_readdatavalid = 1'b0;
        chk("b2b_rd_pready", 32'(bus.APB_PREADY), 1);
        chk("b2b_rd_prdata", bus.APB_PRDATA, 32'h55AA_00FF);
        tick();
        apb_idle();
        tick();

        // long stall on a read
        apb_setup(1'b0, 32'h200, 32'h0);
        bus.amm_waitrequest = 1'b1;
        tick();
        bus.APB_PENABLE = 1'b1;
`ifdef APB2AMM_TIMEOUT_EN
        // counter reaches TIMEOUT=10 on the 11th edge after setup
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("tmo_wait_pready_%0d", i), 32'(bus.APB_PREADY), 0);
        end
        tick();
        chk("tmo_pready",  32'(bus.APB_PREADY), 1);
        chk("tmo_pslverr", 32'(bus.APB_PSLVERR), 1);
        chk("tmo_prdata",  bus.APB_PRDATA, 32'h0);
        chk("tmo_cmd",     32'({bus.amm_write, bus.amm_read}), 0);
        tick();
        apb_idle();
        bus.amm_waitrequest = 1'b0;
        chk("tmo_pslverr_pulse", 32'(bus.APB_PSLVERR), 0);
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h7777_7777;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("tmo_late_pready_%0d", i), 32'(bus.APB_PREADY), 0);
        end
        bus.amm_readdatavalid = 1'b0;
        chk("tmo_late_prdata", bus.APB_PRDATA, 32'h0);
`else
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("stall_pready_%0d", i), 32'(bus.APB_PREADY), 0);
            chk($sformatf("stall_read_%0d", i), 32'(bus.amm_read), 1);
        end
        bus.amm_waitrequest = 1'b0;
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h0BAD_F00D;
        tick();
        bus.amm_readdatavalid = 1'b0;
        chk("stall_pready",  32'(bus.APB_PREADY), 1);
        chk("stall_pslverr", 32'(bus.APB_PSLVERR), 0);
        chk("stall_prdata",  bus.APB_PRDATA, 32'h0BAD_F00D);
        tick();
        apb_idle();
`endif
        tick();

        // reset while a write is stalled in CMD
        apb_setup(1'b1, 32'h300, 32'h1111_2222);
        bus.amm_waitrequest = 1'b1;
        tick();
        bus.APB_PENABLE = 1'b1;
        tick();
        chk("rstcmd_write_pre", 32'(bus.amm_write), 1);
        reset = 1'b1;
        tick();
        chk("rstcmd_cmd",    32'({bus.amm_write, bus.amm_read}), 0);
        chk("rstcmd_pready", 32'(bus.APB_PREADY), 0);
        chk("rstcmd_addr",   bus.amm_address, 32'h0);
        reset = 1'b0;
        apb_idle();
        bus.amm_waitrequest = 1'b0;
        tick();
        chk("rstcmd_idle_pready", 32'(bus.APB_PREADY), 0);
        apb_setup(1'b1, 32'h304, 32'hCAFE_0001);
        tick();
        chk("post_rst_write", 32'(bus.amm_write), 1);
        chk("post_rst_addr",  bus.amm_address, 32'h304);
        chk("post_rst_data",  bus.amm_writedata, 32'hCAFE_0001);
        bus.APB_PENABLE = 1'b1;
        tick();
        chk("post_rst_pready",  32'(bus.APB_PREADY), 1);
        chk("post_rst_pslverr", 32'(bus.APB_PSLVERR), 0);
        tick();
        apb_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
